// File: rtl/memory_router.sv
// Routes CPU bus requests to one of NUM_BANKS banks by address bits, waiting on the
// selected bank's ready with an optional timeout; 4-phase handshake toward the CPU.
module memory_router #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_LSB   = 13,
    parameter logic [NUM_BANKS-1:0] READ_ONLY_MASK = NUM_BANKS'(4'b0010),
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            bus_enable_i,
    input  logic                            write_enable_i,
    input  logic [ADDR_WIDTH-1:0]           address_i,
    input  logic [DATA_WIDTH-1:0]           data_in_i,
    output logic [DATA_WIDTH-1:0]           data_out_o,
    output logic                            bus_done_o,
    output logic                            bus_error_o,
    output logic [NUM_BANKS-1:0]            bank_enable_o,
    output logic [NUM_BANKS-1:0]            bank_write_enable_o,
    output logic [ADDR_WIDTH-1:0]           bank_address_o,
    output logic [DATA_WIDTH-1:0]           bank_data_out_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data_in_i,
    input  logic [NUM_BANKS-1:0]            bank_ready_i
);

    localparam int IDX_W = $clog2(NUM_BANKS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic [IDX_W-1:0]       bank_q, bank_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   err_q, err_d;
    logic [NUM_BANKS-1:0]   en_q, en_d;
    logic [NUM_BANKS-1:0]   wen_q, wen_d;
    logic [IDX_W-1:0]       req_bank;

    assign req_bank = address_i[BANK_LSB +: IDX_W];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // (which would infer a latch); enables default low so they drop outside ACCESS.
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        err_d   = err_q;
        en_d    = '0;
        wen_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus_enable_i) begin
                    addr_d  = address_i;
                    wdata_d = data_in_i;
                    we_d    = write_enable_i;
                    bank_d  = req_bank;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    en_d    = NUM_BANKS'(1) << req_bank;
                    wen_d   = (write_enable_i && !READ_ONLY_MASK[req_bank]) ? en_d : '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bank_ready_i[bank_q]) begin
                    if (!we_q) dout_d = bank_data_in_i[int'(bank_q)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    dout_d  = '1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    en_d  = en_q;
                    wen_d = wen_q;
                end
            end
            DONE: begin
                // No re-issue until the CPU has dropped its request.
                if (!bus_enable_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops see the
    // pre-edge values; the async reset drops the bank enables without a clock.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            bank_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= '0;
            wen_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            en_q    <= en_d;
            wen_q   <= wen_d;
        end
    end

    assign data_out_o          = dout_q;
    assign bus_done_o          = (state_q == DONE);
    assign bus_error_o         = err_q;
    assign bank_enable_o       = en_q;
    assign bank_write_enable_o = wen_q;
    assign bank_address_o      = addr_q;
    assign bank_data_out_o     = wdata_q;

endmodule

// File: tb/tb_memory_router.sv
// Self-checking bench for memory_router: directed scenarios plus randomized accesses
// scored against a transaction-level model of bank selection, wait and timeout rules.
module tb_memory_router;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_enable, write_enable;
    logic [15:0] address, data_in, data_out, bank_address, bank_data_out;
    logic        bus_done, bus_error;
    logic [3:0]  bank_enable, bank_write_enable, bank_ready;
    logic [63:0] bank_data_in;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] bdata [4];
    logic [15:0] exp_dout;
    logic        exp_err;

    memory_router #(.TIMEOUT(TMO)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .bus_enable_i        (bus_enable),
        .write_enable_i      (write_enable),
        .address_i           (address),
        .data_in_i           (data_in),
        .data_out_o          (data_out),
        .bus_done_o          (bus_done),
        .bus_error_o         (bus_error),
        .bank_enable_o       (bank_enable),
        .bank_write_enable_o (bank_write_enable),
        .bank_address_o      (bank_address),
        .bank_data_out_o     (bank_data_out),
        .bank_data_in_i      (bank_data_in),
        .bank_ready_i        (bank_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_banks();
        for (int n = 0; n < 4; n++) bdata[n] = 16'($urandom);
    endtask

    // One complete CPU transaction. Starts and ends at a negedge with the DUT idle.
    // The target bank's ready rises in ACCESS cycle delay+1; other banks stay ready
    // meanwhile so a wrong ready selection shows up as an early completion.
    task automatic run_access(input string name, input logic [15:0] addr, input logic we,
                              input logic [15:0] wd, input int delay, input int hold);
        int          bank;
        int          k;
        int          exp_cycles;
        logic        done;
        logic        timed_out;
        logic [3:0]  exp_en, exp_wen;

        bank       = (int'(addr) >> 13) & 3;
        exp_en     = 4'(1 << bank);
        exp_wen    = (we && bank != 1) ? exp_en : 4'b0000;
        timed_out  = (delay >= TMO);
        exp_cycles = timed_out ? TMO : delay + 1;

        for (int n = 0; n < 4; n++) bank_data_in[n*16 +: 16] = bdata[n];
        bus_enable   = 1'b1;
        write_enable = we;
        address      = addr;
        data_in      = wd;
        @(posedge clk);
        @(negedge clk);
        // Inputs other than bus_enable may now change; the latched copies must be used.
        address      = 16'($urandom);
        data_in      = 16'($urandom);
        write_enable = 1'($urandom);

        k    = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            k++;
            bank_ready = (k > delay) ? 4'hF : ~exp_en;
            check({name, ".en"}, 32'(bank_enable), 32'(exp_en));
            check({name, ".wen"}, 32'(bank_write_enable), 32'(exp_wen));
            if (k == 1) begin
                check({name, ".addr"}, 32'(bank_address), 32'(addr));
                if (we) check({name, ".wdata"}, 32'(bank_data_out), 32'(wd));
                check({name, ".err_clr"}, 32'(bus_error), 32'd0);
                check({name, ".done_lo"}, 32'(bus_done), 32'd0);
            end
            @(posedge clk);
            @(negedge clk);
            done = bus_done;
        end

        if (timed_out) begin
            exp_dout = 16'hFFFF;
            exp_err  = 1'b1;
        end else begin
            exp_err = 1'b0;
            if (!we) exp_dout = bdata[bank];
        end
        check({name, ".cycles"}, 32'(k), 32'(exp_cycles));
        check({name, ".done"}, 32'(bus_done), 32'd1);
        check({name, ".err"}, 32'(bus_error), 32'(exp_err));
        check({name, ".dout"}, 32'(data_out), 32'(exp_dout));

        for (int h = 0; h < hold; h++) begin
            check({name, ".hold_en"}, 32'(bank_enable), 32'd0);
            check({name, ".hold_done"}, 32'(bus_done), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        check({name, ".done_en"}, 32'(bank_enable | bank_write_enable), 32'd0);

        bus_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, ".idle_done"}, 32'(bus_done), 32'd0);
        check({name, ".idle_err"}, 32'(bus_error), 32'(exp_err));
        check({name, ".idle_dout"}, 32'(data_out), 32'(exp_dout));
    endtask

    initial begin
        reset        = 1'b1;
        bus_enable   = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        data_in      = '0;
        bank_ready   = '0;
        bank_data_in = '0;
        exp_dout     = '0;
        exp_err      = 1'b0;
        #12;
        check("rst.dout", 32'(data_out), 32'd0);
        check("rst.done", 32'(bus_done), 32'd0);
        check("rst.err", 32'(bus_error), 32'd0);
        check("rst.en", 32'({bank_enable, bank_write_enable}), 32'd0);
        check("rst.bus", 32'({bank_address, bank_data_out}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        randomize_banks();
        bdata[0] = 16'h1234;
        run_access("rd_b0",     16'h0010, 1'b0, 16'h0000, 0,   0);
        run_access("wr_b3",     16'h6004, 1'b1, 16'hBEEF, 5,   0);
        run_access("wr_ro_b1",  16'h2000, 1'b1, 16'h5A5A, 0,   0);
        randomize_banks();
        run_access("rd_tmo_b2", 16'h4000, 1'b0, 16'h0000, 100, 0);
        run_access("rd_clr_b0", 16'h0000, 1'b0, 16'h0000, 2,   0);
        run_access("rd_edge15", 16'h4321, 1'b0, 16'h0000, 15,  0);
        run_access("wr_tmo16",  16'h7FFE, 1'b1, 16'h1111, 16,  0);
        run_access("rd_hold3",  16'h2468, 1'b0, 16'h0000, 1,   3);

        // Reset in the middle of an access: enables and done drop without a clock edge.
        bus_enable   = 1'b1;
        write_enable = 1'b1;
        address      = 16'h6000;
        data_in      = 16'hCAFE;
        bank_ready   = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid.en", 32'(bank_enable), 32'h8);
        #2 reset = 1'b1;
        #1;
        check("mid.en_drop", 32'({bank_enable, bank_write_enable}), 32'd0);
        check("mid.done", 32'(bus_done), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        bus_enable = 1'b0;
        exp_dout   = '0;
        exp_err    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid.idle", 32'({bus_done, bus_error, bank_enable}), 32'd0);
        check("mid.dout", 32'(data_out), 32'd0);
        randomize_banks();
        run_access("post_rst", 16'h4002, 1'b0, 16'h0000, 0, 0);

        for (int i = 0; i < 30; i++) begin
            int d;
            randomize_banks();
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 6));
            run_access($sformatf("rnd%0d", i), 16'($urandom), 1'($urandom), 16'($urandom),
                       d, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
